counter_sched: RTL and testbench
================================

// Module: counter_sched
// PURPOSE
//  Round-robin scheduler that shares one 8-bit loadable up-counter (load/data/oe_n/count interface) among NREQ requesters.
//  Each accepted job loads a start value, lets the counter run for a requested number of cycles, samples the final count and returns it to the owner.
//  Sits between the requester logic and the counter instance; it is the only driver of the counter's load/data/oe_n.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  W     8  counter / start-value width
//  LW    8  run-length field width
//  IDW   $clog2(NREQ)  requester-id width (derived localparam)
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  rst_n        in   1         synchronous active-low reset
//  req_valid    in   NREQ      job request per requester
//  req_ready    out  NREQ      one-hot accept; handshake = valid&ready
//  req_start    in   NREQ*W    per-requester start value, slice i = [i*W +: W]
//  req_len      in   NREQ*LW   per-requester run length, slice i = [i*LW +: LW]
//  abort        in   1         terminate current job early
//  cnt_load     out  1         to counter load
//  cnt_data     out  W         to counter data
//  cnt_oe_n     out  1         to counter oe_n (active-low output enable)
//  cnt_q        in   W         from counter count
//  busy         out  1         job in progress (state != IDLE)
//  done         out  1         one-cycle completion pulse
//  done_id      out  IDW       owner of completed job
//  done_result  out  W         sampled counter value
//  done_aborted out  1         job ended by abort
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, cnt_data=0, done/done_id/done_result/done_aborted=0; cnt_load=0, cnt_oe_n=1, busy=0.
//  req_ready is combinational: forced 0 while rst_n=0; else (state==IDLE) & grant[i].
//  Reset mid-job: job dropped, no done pulse, outputs at reset values after the edge.
//  Arbiter: grant = first asserted req_valid searching rr_ptr, rr_ptr+1, ... mod NREQ.
//  Arbiter: on accept of i, rr_ptr <= (i+1) mod NREQ.
//  Arbiter: no grant and no ready outside IDLE; requesters hold valid/start/len until accepted.
//  FSM IDLE: on accept of i at cycle T -> latch cnt_data<=start_i, len_r<=len_i, id_r<=i; go LOAD.
//  FSM LOAD (T+1): cnt_load=1. Next state RUN if len_r!=0, DONE if len_r==0 or abort=1.
//  FSM RUN: cnt_load=0, counter increments each cycle. Down-counter rem starts at len_r, decremented once per RUN cycle; leave RUN after len_r cycles (rem==1) -> DONE.
//  FSM RUN: abort=1 in RUN -> DONE next cycle.
//  FSM DONE (T+2+len normally): sample cnt_q; next state IDLE.
//  FSM DONE: registered done=1, done_id=id_r, done_result=cnt_q, done_aborted=abort_seen at cycle T+3+len, for exactly one cycle.
//  FSM DONE: the done cycle coincides with IDLE, so a new accept may happen in that same cycle.
//  cnt_oe_n=0 in LOAD/RUN/DONE, 1 in IDLE (counter free-runs tri-stated while idle).
//  cnt_data holds the last latched start value until the next accept.
//  Arithmetic: result = (start+len) mod 2^W, wraps naturally; len=0 gives result=start.
//  abort in IDLE: ignored. abort in DONE: no effect. abort_seen is cleared on accept.
//  Abort in LOAD gives result=start. Abort in RUN gives the value after the current increment.
//  busy=1 in LOAD/RUN/DONE.
// TESTING
//  1. Hold rst_n=0 2 cycles with all req_valid=1 -> req_ready=0, cnt_oe_n=1, cnt_load=0, done=0, rr_ptr=0.
//  2. req 2 only, start=F0, len=5, accepted T -> cnt_load=1 at T+1; done=1, done_id=2, done_result=F5, done_aborted=0 at T+8; busy low by T+8.
//  3. Wrap: start=FE, len=3 -> done_result=01. len=0, start=3C -> done at T+3, done_result=3C.
//  4. All 4 req_valid held, jobs len=1 -> accept order 0,1,2,3,0; each next accept in the done cycle of the previous job.
//  5. start=10, len=20, abort pulsed in 3rd RUN cycle -> done_aborted=1, done_result=13, done 2 cycles after abort; next job has done_aborted=0.
//  6. rst_n=0 for one cycle during RUN -> no done pulse; busy=0 and cnt_oe_n=1 after the edge; next accept starts from rr_ptr=0.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one loadable up-counter among NREQ requesters:
// each job loads a start value, runs the counter for len cycles and returns the final count.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LW   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_start,
  input  logic [NREQ*LW-1:0]        req_len,
  input  logic                      abort,
  output logic                      cnt_load,
  output logic [W-1:0]              cnt_data,
  output logic                      cnt_oe_n,
  input  logic [W-1:0]              cnt_q,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [W-1:0]              done_result,
  output logic                      done_aborted
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    cnt_data_q, cnt_data_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            abort_seen_q, abort_seen_d;
  logic            cnt_load_q, cnt_load_d;
  logic            cnt_oe_n_q, cnt_oe_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [W-1:0]    done_result_q, done_result_d;
  logic            done_aborted_q, done_aborted_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic            accept;
  int              idx;

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld  = 1'b1;
        grant_id   = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign accept    = rst_n && (state_q == IDLE) && grant_vld;
  assign req_ready = (rst_n && (state_q == IDLE)) ? grant : '0;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    cnt_data_d     = cnt_data_q;
    rem_d          = rem_q;
    abort_seen_d   = abort_seen_q;
    done_d         = 1'b0;
    done_id_d      = '0;
    done_result_d  = '0;
    done_aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_data_d   = req_start[int'(grant_id)*W +: W];
          rem_d        = req_len[int'(grant_id)*LW +: LW];
          id_d         = grant_id;
          abort_seen_d = 1'b0;
          rr_ptr_d     = IDW'((int'(grant_id) + 1) % NREQ);
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          abort_seen_d = 1'b1;
          state_d      = DONE;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_q - 1'b1;
        if (abort) begin
          abort_seen_d = 1'b1;
          state_d      = DONE;
        end else if (rem_q == LW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d         = 1'b1;
        done_id_d      = id_q;
        done_result_d  = cnt_q;
        done_aborted_d = abort_seen_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Counter controls are registered from the next state so they align with it.
    cnt_load_d = (state_d == LOAD);
    cnt_oe_n_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      cnt_data_q     <= '0;
      rem_q          <= '0;
      abort_seen_q   <= 1'b0;
      cnt_load_q     <= 1'b0;
      cnt_oe_n_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_id_q      <= '0;
      done_result_q  <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      cnt_data_q     <= cnt_data_d;
      rem_q          <= rem_d;
      abort_seen_q   <= abort_seen_d;
      cnt_load_q     <= cnt_load_d;
      cnt_oe_n_q     <= cnt_oe_n_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      done_id_q      <= done_id_d;
      done_result_q  <= done_result_d;
      done_aborted_q <= done_aborted_d;
    end
  end

  assign cnt_load     = cnt_load_q;
  assign cnt_data     = cnt_data_q;
  assign cnt_oe_n     = cnt_oe_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign done_result  = done_result_q;
  assign done_aborted = done_aborted_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural loadable up-counter attached.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LW   = 8;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_start;
  logic [NREQ*LW-1:0] req_len;
  logic               abort;
  logic               cnt_load;
  logic [W-1:0]       cnt_data;
  logic               cnt_oe_n;
  logic [W-1:0]       cnt_q;
  logic               busy;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic [W-1:0]       done_result;
  logic               done_aborted;

  int n_vec = 0;
  int n_bad = 0;

  counter_sched #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_len(req_len), .abort(abort),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_oe_n(cnt_oe_n), .cnt_q(cnt_q),
    .busy(busy), .done(done), .done_id(done_id), .done_result(done_result),
    .done_aborted(done_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: loads on cnt_load, otherwise free-runs.
  logic [W-1:0] ctr = '0;
  always_ff @(posedge clk) begin
    if (cnt_load) ctr <= cnt_data;
    else          ctr <= ctr + 1'b1;
  end
  assign cnt_q = ctr;

  typedef struct {
    int         id;
    logic [7:0] start;
    logic [7:0] len;
    int         abort_cyc;   // cycle after accept with abort high (1 = LOAD), 0 = none
    bit         idle_abort;
    logic [7:0] exp_res;
    bit         exp_ab;
    int         exp_lat;     // cycles from accept edge to done
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    bit got;
    int lat;
    got = 0;
    lat = 0;
    if (v.idle_abort) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    req_valid = 4'b0001 << v.id;
    req_start[v.id*8 +: 8] = v.start;
    req_len[v.id*8 +: 8]   = v.len;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[v.id]) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d accept", n), 32'(got), 32'd1);
    if (!got) begin req_valid = '0; return; end
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 1; c <= 40; c++) begin
      abort = (c == v.abort_cyc);
      @(negedge clk);
      if (c == 1) chk($sformatf("v%0d cnt_load", n), 32'(cnt_load), 32'd1);
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d done_id", n), 32'(done_id), 32'(v.id));
    chk($sformatf("v%0d done_result", n), 32'(done_result), 32'(v.exp_res));
    chk($sformatf("v%0d done_aborted", n), 32'(done_aborted), 32'(v.exp_ab));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", n), 32'(done), 32'd0);
    chk($sformatf("v%0d busy_after", n), 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int k;
    int prev;
    bit seen;
    rst_n     = 1'b0;
    req_valid = '0;
    req_start = '0;
    req_len   = '0;
    abort     = 1'b0;

    tbl[0] = '{2, 8'hF0, 8'h05, 0, 0, 8'hF5, 0, 8};
    tbl[1] = '{0, 8'hFE, 8'h03, 0, 0, 8'h01, 0, 6};
    tbl[2] = '{1, 8'h3C, 8'h00, 0, 0, 8'h3C, 0, 3};
    tbl[3] = '{3, 8'h10, 8'h14, 4, 0, 8'h13, 1, 6};
    tbl[4] = '{0, 8'h10, 8'h02, 0, 1, 8'h12, 0, 5};
    tbl[5] = '{2, 8'h55, 8'h04, 1, 0, 8'h55, 1, 3};
    tbl[6] = '{1, 8'hFF, 8'h01, 0, 0, 8'h00, 0, 4};
    tbl[7] = '{3, 8'h20, 8'h03, 4, 0, 8'h23, 1, 6};
    tbl[8] = '{0, 8'h80, 8'h02, 4, 0, 8'h82, 0, 5};

    // Reset held two cycles with every requester asking
    req_valid = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'h0);
    end
    chk("rst cnt_oe_n", 32'(cnt_oe_n), 32'd1);
    chk("rst cnt_load", 32'(cnt_load), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cnt_data", 32'(cnt_data), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst rr_ptr grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(posedge clk); #1;

    for (int n = 0; n < 9; n++) run_vec(tbl[n], n);

    // Round robin with all requesters held, len=1 jobs
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_start[i*8 +: 8] = 8'(8'h40 + i * 8'h11);
      req_len[i*8 +: 8]   = 8'h01;
    end
    req_valid = 4'hF;
    k = 0;
    prev = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        chk($sformatf("rr accept %0d", k), 32'(req_ready), 32'(4'b0001 << exp_order[k]));
        if (k > 0) begin
          chk($sformatf("rr done coincide %0d", k), 32'(done), 32'd1);
          chk($sformatf("rr done_id %0d", k), 32'(done_id), 32'(prev));
          chk($sformatf("rr done_result %0d", k), 32'(done_result), 32'(8'h41 + prev * 8'h11));
        end
        prev = exp_order[k];
        k++;
      end
      @(posedge clk); #1;
    end
    chk("rr accept count", 32'(k), 32'd5);
    req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("rr last done", 32'(seen), 32'd1);

    // Reset during RUN drops the job
    req_start[8 +: 8] = 8'h00;
    req_len[8 +: 8]   = 8'd20;
    req_valid = 4'b0010;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready[1]) seen = 1;
      @(posedge clk); #1;
    end
    chk("mid accept", 32'(seen), 32'd1);
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid cnt_oe_n", 32'(cnt_oe_n), 32'd1);
    chk("mid cnt_load", 32'(cnt_load), 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("mid no done", 32'(seen), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("mid rr_ptr reset", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
